// File: rtl/engine_filter_cond_gate_pkg.sv
// engine_filter_cond_gate_pkg: packet type, gate FSM states and parameter defaults
package engine_filter_cond_gate_pkg;
    localparam int ENGINE_PACKET_DATA_NUM_FIELDS = 4;
    typedef struct packed {
        logic [15:0] field3;
        logic [15:0] field2;
        logic [15:0] field1;
        logic [15:0] field0;
    } EnginePacketData;
    typedef enum logic [1:0] {IDLE, RUN, SLACK, FLUSH} FilterGateState;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int PIPE_SLACK_DEFAULT = 4;
    localparam int COUNT_W_DEFAULT    = 32;
endpackage

// File: rtl/engine_filter_cond_gate_fifo.sv
// engine_filter_cond_gate_fifo: first-word-fall-through FIFO with occupancy count
module engine_filter_cond_gate_fifo
    import engine_filter_cond_gate_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            wr,
    input  logic            rd,
    input  EnginePacketData wdata,
    output EnginePacketData rdata,
    output logic [AW:0]     count,
    output logic            full,
    output logic            empty
);
    EnginePacketData r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_wr, w_rd;
    // a write at full is legal when the head leaves in the same cycle
    assign w_rd  = rd & ~empty;
    assign w_wr  = wr & (~full | w_rd);
    assign count = r_count;
    assign full  = r_count == (AW+1)'(DEPTH);
    assign empty = r_count == '0;
    assign rdata = empty ? '0 : r_mem[r_rptr];
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end
endmodule

// File: rtl/engine_filter_cond_gate.sv
// engine_filter_cond_gate: drops result_bool=0 packets, buffers the rest, stalls early and drains on request
module engine_filter_cond_gate
    import engine_filter_cond_gate_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int PIPE_SLACK = PIPE_SLACK_DEFAULT,
    parameter int COUNT_W    = COUNT_W_DEFAULT
) (
    input  logic               ap_clk,
    input  logic               areset,
    input  logic               clear,
    input  logic               in_valid,
    input  EnginePacketData    in_data,
    input  logic               in_bool,
    output logic               in_stall,
    input  logic               drain_req,
    output logic               out_valid,
    output EnginePacketData    out_data,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] pass_count,
    output logic [COUNT_W-1:0] drop_count,
    output logic               overflow,
    output logic               done,
    output logic               busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(PIPE_SLACK + 1);
    FilterGateState     r_state;
    logic [SW-1:0]      r_slack;
    logic [COUNT_W-1:0] r_pass, r_drop;
    logic               r_overflow, r_done, r_stall;
    logic [AW:0]        w_count;
    logic               w_full, w_empty, w_acc, w_keep, w_rd, w_wr, w_ovf;
    assign w_acc      = in_valid & (r_state != FLUSH);
    assign w_keep     = w_acc & in_bool;
    assign w_rd       = out_valid & out_ready;
    assign w_wr       = w_keep & (~w_full | w_rd);
    assign w_ovf      = w_keep & w_full & ~w_rd;
    assign out_valid  = ~w_empty;
    assign busy       = r_state != IDLE;
    assign in_stall   = r_stall | (r_state == FLUSH);
    assign pass_count = r_pass;
    assign drop_count = r_drop;
    assign overflow   = r_overflow;
    assign done       = r_done;
    engine_filter_cond_gate_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (ap_clk),
        .rst   (areset),
        .clr   (clear),
        .wr    (w_wr),
        .rd    (w_rd),
        .wdata (in_data),
        .rdata (out_data),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_state    <= IDLE;
            r_slack    <= '0;
            r_pass     <= '0;
            r_drop     <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_stall    <= 1'b0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_slack    <= '0;
            r_pass     <= '0;
            r_drop     <= '0;
            r_done     <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_stall <= w_count >= (AW+1)'(FIFO_DEPTH - PIPE_SLACK);
            if (w_ovf) r_overflow <= 1'b1;
            if (w_wr && !(&r_pass)) r_pass <= r_pass + 1'b1;
            if (w_acc && !in_bool && !(&r_drop)) r_drop <= r_drop + 1'b1;
            case (r_state)
                IDLE: begin
                    if (drain_req) begin
                        r_state <= SLACK;
                        r_slack <= '0;
                    end else if (in_valid) r_state <= RUN;
                end
                RUN: begin
                    if (drain_req) begin
                        r_state <= SLACK;
                        r_slack <= '0;
                    end
                end
                SLACK: begin
                    r_slack <= r_slack + 1'b1;
                    if (r_slack == SW'(PIPE_SLACK - 1)) r_state <= FLUSH;
                end
                FLUSH: begin
                    if (w_empty) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/engine_filter_cond_gate.md
Name: engine_filter_cond_gate

Overview:
Consumer stage on the output side of the filter-condition kernel.
- Takes the kernel's result_flag/result/result_bool triple and drops packets whose result_bool is 0.
- Buffers passing packets in a small FIFO and presents them downstream on a valid/ready interface.
- Raises a stall early enough to cover the kernel's in-flight pipeline, and runs an end-of-stream drain sequence with a done pulse and pass/drop statistics.

Parameters:
FIFO_DEPTH, 16, entries of EnginePacketData; power of two, >= 2*PIPE_SLACK.
PIPE_SLACK, 4, cycles of results that may still arrive after in_stall rises (kernel latency 3 + 1 register).
COUNT_W, 32, width of the pass/drop statistic counters.

Ports:
ap_clk  input  1  clock; all logic on the rising edge.
areset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush; same effect as reset, excluding the overflow flag.
in_valid  input  1  kernel result_flag.
in_data  input  EnginePacketData  kernel result.
in_bool  input  1  kernel result_bool; 1 = keep the packet.
in_stall  output  1  backpressure toward the kernel's feeder.
drain_req  input  1  single-cycle pulse: upstream has sent its last packet.
out_valid  output  1  out_data holds a valid packet.
out_data  output  EnginePacketData  head of the FIFO.
out_ready  input  1  downstream accepts out_data.
pass_count  output  COUNT_W  packets written to the FIFO.
drop_count  output  COUNT_W  packets discarded because in_bool=0.
overflow  output  1  sticky; a keep-packet arrived while the FIFO was full.
done  output  1  single-cycle pulse when the drain completes.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (areset, asynchronous) values: every output is 0; FIFO is empty; state is IDLE.
- clear (synchronous) applies the same values, except that overflow is held.
- States: IDLE, RUN, SLACK, FLUSH.
  - IDLE -> RUN on the first in_valid.
  - RUN -> SLACK on drain_req. drain_req seen in IDLE goes directly to SLACK.
  - SLACK counts PIPE_SLACK cycles and keeps accepting input throughout; then -> FLUSH.
  - FLUSH ignores in_valid. It goes -> IDLE when the FIFO is empty and no read is pending, pulsing done for one cycle on that same edge.
- Accept rule: in_valid is honoured in IDLE, RUN and SLACK.
  - in_bool=1: write to the FIFO and increment pass_count.
  - in_bool=0: no write; increment drop_count.
  - Both counters saturate at all-ones.
- Full boundary: a write when count==FIFO_DEPTH and no read that cycle drops the packet, sets overflow, and does not increment pass_count.
  - Write and read in the same cycle at full are both accepted; count is unchanged.
- in_stall = (count >= FIFO_DEPTH-PIPE_SLACK), registered. It is also forced to 1 in FLUSH.
- Output is first-word-fall-through.
  - out_valid = (count != 0).
  - A read occurs when out_valid & out_ready. out_data changes only after a read.
  - Write-to-out_valid latency is 1 cycle, so a packet can appear at the output at the earliest 1 cycle after in_valid.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- A drain_req during SLACK or FLUSH is ignored.
- Reset or clear mid-FLUSH discards the FIFO contents and gives no done pulse.

Decomposition:
- Package (global_package): add FilterGateState enum {IDLE, RUN, SLACK, FLUSH} and the parameter defaults. EnginePacketData and ENGINE_PACKET_DATA_NUM_FIELDS are already defined there.
- One sub-module: engine_filter_cond_gate_fifo, a synchronous FWFT FIFO with count, full and empty outputs. The top level holds the FSM, counters and stall logic.

Test Plan:
- Alternating keep/drop: 8 in_valid with in_bool 1,0,1,0,1,0,1,0 and field0 = 1..8, out_ready=1 -> output stream is 1,3,5,7; pass_count=4, drop_count=4.
- Stall threshold: out_ready=0, 12 keep-packets -> in_stall=1 on the cycle after count reaches 12. A further 4 packets fill the FIFO to 16 with overflow=0; a 17th sets overflow and leaves pass_count=16.
- Full plus simultaneous read: count=16, in_valid/in_bool=1 with out_ready=1 -> count stays 16, overflow stays 0, ordering is preserved.
- Drain: 5 packets buffered, out_ready=0, then drain_req followed by 2 more packets within 4 cycles. Hold out_ready=0 for 10 cycles, then 1 -> all 7 packets exit in order, and done pulses once, one cycle after the last read.
- Mid-drain clear: in FLUSH with 3 entries, assert clear -> out_valid=0, counters=0, state IDLE, no done pulse.
- Asynchronous reset: areset mid-packet, between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
